// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter
//   Round-robin arbiter that merges SRC_CNT AXI-Stream requesters onto a
//   single Aurora TX stream. Whole packets are granted at a time; a packet
//   cut short by channel loss is drained from its source and counted.
//
// Ports
//   clk, rst      : user clock, synchronous active-high reset
//   channel_up    : Aurora channel status (clk domain)
//   s_tdata/tkeep/tvalid/tlast/tready : per-requester AXIS slave ports
//   m_tdata/tkeep/tvalid/tlast/tready : AXIS master port to Aurora TX
//   grant         : index of the current (or last) granted requester
//   busy          : high while a packet is being sent or drained
//   drop_cnt      : saturating count of packets truncated by channel loss
module aurora_tx_arbiter #(
  parameter int SRC_CNT = 4,
  parameter int DATA_W  = 128,
  parameter int KEEP_W  = 16,
  localparam int GW     = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            channel_up,
  input  logic [SRC_CNT-1:0][DATA_W-1:0]  s_tdata,
  input  logic [SRC_CNT-1:0][KEEP_W-1:0]  s_tkeep,
  input  logic [SRC_CNT-1:0]              s_tvalid,
  input  logic [SRC_CNT-1:0]              s_tlast,
  output logic [SRC_CNT-1:0]              s_tready,
  output logic [DATA_W-1:0]               m_tdata,
  output logic [KEEP_W-1:0]               m_tkeep,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [GW-1:0]                   grant,
  output logic                            busy,
  output logic [15:0]                     drop_cnt
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t        state;
  logic [GW-1:0] next_grant;
  logic [GW-1:0] cand;
  logic          req_found;
  logic          cur_valid;
  logic          cur_last;
  logic          xfer_done;

  assign cur_valid = s_tvalid[grant];
  assign cur_last  = s_tlast[grant];
  assign busy      = (state != IDLE);

  // The last beat of a packet is only accepted while the channel is up;
  // a channel drop in the same cycle sends the packet to DRAIN instead.
  assign xfer_done = (state == XFER) && channel_up && cur_valid && m_tready && cur_last;

  // Cyclic search starting one past the last grant; the final iteration
  // (i == SRC_CNT) revisits the last grant itself so a lone requester can
  // be re-granted.
  always_comb begin
    next_grant = grant;
    req_found  = 1'b0;
    cand       = '0;
    for (int i = 1; i <= SRC_CNT; i++) begin
      cand = GW'((int'(grant) + i) % SRC_CNT);
      if (!req_found && s_tvalid[cand]) begin
        req_found  = 1'b1;
        next_grant = cand;
      end
    end
  end

  // Datapath mux. In XFER the granted source is passed straight through.
  // s_tready is gated by channel_up so that a beat is never consumed in a
  // cycle where m_tvalid is suppressed; DRAIN then swallows the remainder.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    case (state)
      XFER: begin
        m_tdata         = s_tdata[grant];
        m_tkeep         = s_tkeep[grant];
        m_tvalid        = cur_valid & channel_up;
        m_tlast         = cur_last;
        s_tready[grant] = m_tready & channel_up;
      end
      DRAIN: begin
        s_tready[grant] = 1'b1;
      end
      default: ;
    endcase
  end

  // Packet-level FSM. Reset leaves grant at SRC_CNT-1 so source 0 is the
  // first candidate. Returning to IDLE after every packet provides the
  // one-cycle arbitration bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= GW'(SRC_CNT - 1);
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (channel_up && req_found) begin
            grant <= next_grant;
            state <= XFER;
          end
        end
        XFER: begin
          if (!channel_up) begin
            state <= DRAIN;
            if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 16'd1;
            end
          end else if (xfer_done) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (cur_valid && cur_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aurora_tx_arbiter.md
AURORA_TX_ARBITER -- requirements
Module: aurora_tx_arbiter

Interface
REQ-001 The block SHALL have parameter SRC_CNT, default 4, giving the number of AXIS TX requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 128, giving the AXIS data width in bits.
REQ-003 The block SHALL have parameter KEEP_W, default 16, giving the byte-enable width (DATA_W/8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock (Aurora user clock domain).
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port channel_up, input, 1 bit: Aurora channel status, already in the clk domain.
REQ-007 The block SHALL have port s_tdata, input, [SRC_CNT-1:0][DATA_W-1:0]: requester data.
REQ-008 The block SHALL have port s_tkeep, input, [SRC_CNT-1:0][KEEP_W-1:0]: requester byte enables.
REQ-009 The block SHALL have port s_tvalid, input, [SRC_CNT-1:0]: requester valid.
REQ-010 The block SHALL have port s_tlast, input, [SRC_CNT-1:0]: requester end of packet.
REQ-011 The block SHALL have port s_tready, output, [SRC_CNT-1:0]: requester ready.
REQ-012 The block SHALL have port m_tdata, output, DATA_W: data to the Aurora TX.
REQ-013 The block SHALL have port m_tkeep, output, KEEP_W: byte enables to the Aurora TX.
REQ-014 The block SHALL have port m_tvalid, output, 1 bit: valid to the Aurora TX.
REQ-015 The block SHALL have port m_tlast, output, 1 bit: end of packet to the Aurora TX.
REQ-016 The block SHALL have port m_tready, input, 1 bit: ready from the Aurora TX.
REQ-017 The block SHALL have port grant, output, $clog2(SRC_CNT) bits: the index of the current or last granted requester.
REQ-018 The block SHALL have port busy, output, 1 bit: high in XFER or DRAIN.
REQ-019 The block SHALL have port drop_cnt, output, 16 bits: the number of packets truncated by channel loss.

Function
REQ-020 The FSM SHALL have three states: IDLE, XFER and DRAIN.
REQ-021 In IDLE with channel_up=1 and s_tvalid!=0, the FSM SHALL register grant to the first requester with tvalid=1, searching cyclically from (last grant + 1) mod SRC_CNT, and move to XFER on the next edge.
REQ-022 In IDLE, all s_tready bits and m_tvalid SHALL be 0; a request first seen in cycle N gives its first m_tvalid in cycle N+1.
REQ-023 In XFER, m_tdata, m_tkeep, m_tvalid and m_tlast SHALL be combinational copies of the granted source; s_tready[grant] SHALL equal m_tready; all other s_tready bits SHALL be 0 (zero added latency).
REQ-024 In XFER, a handshake with m_tlast=1 while channel_up=1 SHALL return the FSM to IDLE; the grant is held until that handshake, so packets are never interleaved.
REQ-025 The FSM SHALL spend at least one IDLE cycle between packets (arbitration bubble).
REQ-026 In XFER with channel_up=0 in a cycle, m_tvalid SHALL be 0 in that cycle; if no tlast handshake has completed, the FSM SHALL go to DRAIN and drop_cnt SHALL increment.
REQ-027 In DRAIN, m_tvalid SHALL be 0 and s_tready[grant]=1; granted beats SHALL be discarded until a beat with tlast=1 is accepted, then the FSM SHALL go to IDLE; channel_up is ignored in DRAIN.
REQ-028 A packet interrupted in REQ-026 SHALL NOT resume when channel_up returns.
REQ-029 drop_cnt SHALL saturate at 0xFFFF.
REQ-030 A single-beat packet (tvalid and tlast in the first XFER cycle with m_tready=1) SHALL complete in one XFER cycle.
REQ-031 m_tready=0 in XFER SHALL stall the source with no beat loss or duplication; the m_* outputs SHALL be held stable by the source per AXIS rules.
REQ-032 busy SHALL be 1 exactly when the state is XFER or DRAIN.

Reset
REQ-033 With rst=1 at a clk edge, the block SHALL enter IDLE, set grant to SRC_CNT-1 (so that source 0 wins first), and clear drop_cnt to 0.
REQ-034 During and after reset, m_tvalid, m_tlast, s_tready and busy SHALL be 0, and m_tdata and m_tkeep SHALL be 0.
REQ-035 Reset asserted mid-XFER or mid-DRAIN SHALL abandon the packet without incrementing drop_cnt.

Verification
REQ-036 Scenario: after reset, sources 0 and 2 each present a 3-beat packet with m_tready=1 and channel_up=1 -> packet 0 (3 beats), 1 idle cycle, packet 2 (3 beats), then grant=2.
REQ-037 Scenario: all 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0 and every packet contiguous on m_*.
REQ-038 Scenario: m_tready toggles 1,0,1,0 during a 4-beat packet -> exactly 4 accepted beats, in order, with data matching the source.
REQ-039 Scenario: channel_up drops after beat 2 of a 5-beat packet -> m_tvalid=0 from that cycle, beats 3..5 consumed silently, drop_cnt=1, back to IDLE.
REQ-040 Scenario: rst pulsed mid-packet -> all outputs 0 on the next cycle, drop_cnt=0, and the next arbitration starts at source 0.
REQ-041 Scenario: channel_up=0 with requests pending -> the FSM stays in IDLE and all s_tready bits stay 0.
